// File: rtl/half_center_cpg_pkg.sv
// Shared definitions for the half-centre CPG: state encodings, phase codes
// and small decode helpers used by the top-level FSM.
package half_center_cpg_pkg;

    typedef enum logic [2:0] {
        HCPG_IDLE    = 3'd0,
        HCPG_BURST_A = 3'd1,
        HCPG_DEAD_AB = 3'd2,
        HCPG_BURST_B = 3'd3,
        HCPG_DEAD_BA = 3'd4
    } hcpg_state_e;

    localparam logic [1:0] PH_A   = 2'b10;
    localparam logic [1:0] PH_B   = 2'b01;
    localparam logic [1:0] PH_OFF = 2'b00;

    // Phase bus seen downstream for a given state; 2'b11 is unreachable.
    function automatic logic [1:0] phase_of(input hcpg_state_e s);
        case (s)
            HCPG_BURST_A: phase_of = PH_A;
            HCPG_BURST_B: phase_of = PH_B;
            default:      phase_of = PH_OFF;
        endcase
    endfunction

    // True while one of the neurons is bursting (fatigue accumulates).
    function automatic logic is_burst(input hcpg_state_e s);
        is_burst = (s == HCPG_BURST_A) || (s == HCPG_BURST_B);
    endfunction

endpackage

// File: rtl/hcpg_fatigue_acc.sv
// Fatigue accumulator: adds the tonic drive on every tick while active and
// flags the tick on which the accumulated fatigue reaches THRESH. The add is
// one bit wider than the register so it can never wrap before the compare.
module hcpg_fatigue_acc #(
    parameter int FAT_W  = 16,
    parameter int THRESH = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       tick,
    input  logic [7:0] drive,
    output logic       hit
);

    localparam logic [FAT_W:0] THRESH_W = (FAT_W+1)'(THRESH);

    logic [FAT_W-1:0] fat_q;
    logic [FAT_W-1:0] fat_d;
    logic [FAT_W:0]   sum_s;
    logic             reach_s;

    assign sum_s   = {1'b0, fat_q} + {{(FAT_W-7){1'b0}}, drive};
    assign reach_s = (sum_s >= THRESH_W);
    assign hit     = (~clr) & tick & reach_s;

    // Next fatigue: cleared when idle/dead/terminating, otherwise accumulate.
    always_comb begin
        fat_d = fat_q;
        if (clr) begin
            fat_d = '0;
        end else if (tick) begin
            if (reach_s) begin
                fat_d = '0;
            end else begin
                fat_d = sum_s[FAT_W-1:0];
            end
        end else begin
            fat_d = fat_q;
        end
    end

    // Fatigue register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fat_q <= '0;
        end else begin
            fat_q <= fat_d;
        end
    end

endmodule

// File: rtl/half_center_cpg.sv
// Half-centre central pattern generator. Two mutually inhibiting neurons
// (A = flexor, B = extensor) alternate bursts whose length is set by a
// fatigue accumulator; an optional dead band separates the bursts.
// Optional feature macro: HCPG_STATS_EN adds the cycle_count port/counter.
module half_center_cpg
    import half_center_cpg_pkg::*;
#(
    parameter int FAT_W      = 16,
    parameter int THRESH     = 1000,
    parameter int DEAD_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        tick,
    input  logic [7:0]  drive,
    output logic [1:0]  phase,
    output logic        switch_pulse
`ifdef HCPG_STATS_EN
    ,
    output logic [15:0] cycle_count
`endif
);

    localparam int              CNT_W    = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (DEAD_TICKS > 0) ? CNT_W'(DEAD_TICKS - 1) : '0;
    localparam logic            DIRECT   = (DEAD_TICKS == 0);

    hcpg_state_e      state_q;
    hcpg_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       phase_q;
    logic             pulse_q;
    logic             pulse_d;
    logic             clr_s;
    logic             hit_s;

    // Fatigue only runs during a burst with the oscillator enabled; this also
    // guarantees every burst starts from zero and that a disable on a
    // terminating tick suppresses the hit.
    assign clr_s = (~enable) | (~is_burst(state_q));

    hcpg_fatigue_acc #(
        .FAT_W  (FAT_W),
        .THRESH (THRESH)
    ) u_fatigue (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .tick  (tick),
        .drive (drive),
        .hit   (hit_s)
    );

    // Next-state, dead-band counter and switch pulse decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!enable) begin
            state_d = HCPG_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HCPG_IDLE: begin
                    state_d = HCPG_BURST_A;
                end
                HCPG_BURST_A: begin
                    if (hit_s) begin
                        pulse_d = 1'b1;
                        state_d = DIRECT ? HCPG_BURST_B : HCPG_DEAD_AB;
                    end else begin
                        state_d = HCPG_BURST_A;
                    end
                end
                HCPG_DEAD_AB: begin
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = HCPG_BURST_B;
                        end else begin
                            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d = HCPG_DEAD_AB;
                    end
                end
                HCPG_BURST_B: begin
                    if (hit_s) begin
                        pulse_d = 1'b1;
                        state_d = DIRECT ? HCPG_BURST_A : HCPG_DEAD_BA;
                    end else begin
                        state_d = HCPG_BURST_B;
                    end
                end
                HCPG_DEAD_BA: begin
                    if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = HCPG_BURST_A;
                        end else begin
                            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d = HCPG_DEAD_BA;
                    end
                end
                default: begin
                    state_d = HCPG_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, dead counter and registered outputs; phase is decoded from the
    // next state so it changes on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HCPG_IDLE;
            cnt_q   <= '0;
            phase_q <= PH_OFF;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_of(state_d);
            pulse_q <= pulse_d;
        end
    end

    assign phase        = phase_q;
    assign switch_pulse = pulse_q;

`ifdef HCPG_STATS_EN
    logic [15:0] cycle_q;
    logic [15:0] cycle_d;

    // One full period completes each time BURST_A is re-entered from the B side.
    always_comb begin
        cycle_d = cycle_q;
        if ((state_d == HCPG_BURST_A) &&
            ((state_q == HCPG_DEAD_BA) || (state_q == HCPG_BURST_B))) begin
            cycle_d = cycle_q + 16'd1;
        end else begin
            cycle_d = cycle_q;
        end
    end

    // Period counter; only the async reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= 16'd0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_count = cycle_q;
`endif

endmodule
